// File: rtl/i2s_mic_array_rx.sv
// Multi-line I2S microphone receiver: generates bclk/lrc, deserialises NUM_LINES stereo lines into a valid/ready frame.
// Optional build macro MIC_DBG_TRIG_EN enables the dbg_trig frame-start pulse; otherwise dbg_trig is tied low.
module i2s_mic_array_rx #(
    parameter int NUM_LINES = 2,
    parameter int DATA_W    = 24,
    parameter int SLOT_BITS = 32,
    parameter int CLK_DIV   = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          en,
    input  logic [NUM_LINES-1:0]          mic_sd,
    output logic                          mic_bclk,
    output logic                          mic_lrc,
    output logic [NUM_LINES*DATA_W-1:0]   pcm_l,
    output logic [NUM_LINES*DATA_W-1:0]   pcm_r,
    output logic                          pcm_valid,
    input  logic                          pcm_ready,
    output logic                          overrun,
    output logic                          dbg_trig
);
    localparam int DIV_W      = $clog2(CLK_DIV);
    localparam int BIT_W      = $clog2(2*SLOT_BITS);
    localparam int FRAME_LAST = 2*SLOT_BITS - 1;
    localparam int PW         = NUM_LINES*DATA_W;

    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt, pos;
    logic [NUM_LINES-1:0] sd_meta, sd_sync;
    logic [PW-1:0]        shift_l, shift_r, shift_l_nxt, shift_r_nxt, shadow;
    logic                 tick, rise, fall, slot, capture, frame_done;

    assign tick    = (div_cnt == DIV_W'(CLK_DIV-1));
    assign rise    = en && tick && !mic_bclk;
    assign fall    = en && tick && mic_bclk;
    assign bit_nxt = (bit_cnt == BIT_W'(FRAME_LAST)) ? '0 : bit_cnt + 1'b1;
    assign slot    = (bit_cnt >= BIT_W'(SLOT_BITS));
    assign pos     = slot ? bit_cnt - BIT_W'(SLOT_BITS) : bit_cnt;
    // pos 0 is the I2S one-bit delay; only bits 1..DATA_W carry the sample
    assign capture = rise && (pos >= BIT_W'(1)) && (pos <= BIT_W'(DATA_W));

    always_comb begin
        shift_l_nxt = shift_l;
        shift_r_nxt = shift_r;
        for (int i = 0; i < NUM_LINES; i++) begin
            shift_l_nxt[i*DATA_W +: DATA_W] = {shift_l[i*DATA_W +: DATA_W-1], sd_sync[i]};
            shift_r_nxt[i*DATA_W +: DATA_W] = {shift_r[i*DATA_W +: DATA_W-1], sd_sync[i]};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sd_meta <= '0;
            sd_sync <= '0;
        end else begin
            sd_meta <= mic_sd;
            sd_sync <= sd_meta;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            mic_bclk   <= 1'b0;
            mic_lrc    <= 1'b0;
            shift_l    <= '0;
            shift_r    <= '0;
            shadow     <= '0;
            frame_done <= 1'b0;
        end else if (!en) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            mic_bclk   <= 1'b0;
            mic_lrc    <= 1'b0;
            shift_l    <= '0;
            shift_r    <= '0;
            shadow     <= '0;
            frame_done <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                mic_bclk <= !mic_bclk;
            if (fall) begin
                bit_cnt <= bit_nxt;
                mic_lrc <= (bit_nxt >= BIT_W'(SLOT_BITS));
            end
            if (capture && !slot)
                shift_l <= shift_l_nxt;
            if (capture && slot)
                shift_r <= shift_r_nxt;
            // Shadow the left half so the next left slot can refill shift_l freely
            if (rise && !slot && pos == BIT_W'(DATA_W))
                shadow <= shift_l_nxt;
            frame_done <= rise && slot && (pos == BIT_W'(DATA_W));
        end
    end

    // Output holding register; its handshake runs independently of en
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pcm_l     <= '0;
            pcm_r     <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (frame_done && (!pcm_valid || pcm_ready)) begin
            pcm_l     <= shadow;
            pcm_r     <= shift_r;
            pcm_valid <= 1'b1;
        end else begin
            if (frame_done)
                overrun <= 1'b1;
            if (pcm_ready)
                pcm_valid <= 1'b0;
        end
    end

`ifdef MIC_DBG_TRIG_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            dbg_trig <= 1'b0;
        else
            dbg_trig <= fall && (bit_cnt == BIT_W'(FRAME_LAST));
    end
`else
    assign dbg_trig = 1'b0;
`endif

endmodule
